// File: rtl/ripple_mon_pkg.sv
// rtl/ripple_mon_pkg.sv - shared types and default widths for the ripple count monitor
package ripple_mon_pkg;

  localparam int CNT_W  = 4;
  localparam int WRAP_W = 8;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - per-bit two-flop synchronizer with async active-low reset
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // Two back-to-back flops per bit; each bit resolves independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/ripple_count_monitor.sv
// rtl/ripple_count_monitor.sv - synchronizes a ripple count, filters unsettled samples, tracks wraps and skips
module ripple_count_monitor #(
  parameter int CNT_W  = ripple_mon_pkg::CNT_W,
  parameter int WRAP_W = ripple_mon_pkg::WRAP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  count_in,
  input  logic [CNT_W-1:0]  thresh,
  input  logic              clr,
  output logic [CNT_W-1:0]  count_out,
  output logic              count_vld,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              above_thresh,
  output logic              skip_err
);

  import ripple_mon_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] w_s2;
  logic [CNT_W-1:0] r_s2_d;
  logic [1:0]       r_fill;
  logic [CNT_W-1:0] w_next_exp;
  logic             w_stable;
  logic             w_load;
  logic             w_wrap;
  logic             w_skip;

  sync_2ff #(
    .WIDTH (CNT_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (count_in),
    .o_q   (w_s2)
  );

  // Delay the synchronized value one cycle so settling can be detected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_d <= '0;
    end else begin
      r_s2_d <= w_s2;
    end
  end

  // Count edges after reset until s2 and s2_d both hold real samples,
  // so the reset zeros in the pipeline are never taken as a stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= 2'd0;
    end else if (r_fill != 2'd3) begin
      r_fill <= r_fill + 2'd1;
    end
  end

  // Stability filter and wrap/skip classification of the incoming sample.
  always_comb begin
    w_next_exp = count_out + CNT_W'(1);
    w_stable   = (w_s2 == r_s2_d) && (r_fill == 2'd3);
    w_load     = w_stable && ((r_state == ST_INIT) || (w_s2 != count_out));
    w_wrap     = w_load && (r_state == ST_TRACK) &&
                 (count_out == {CNT_W{1'b1}}) && (w_s2 == '0);
    // all-ones -> 0 equals old+1 modulo 2^CNT_W, so a wrap never flags a skip
    w_skip     = w_load && (r_state == ST_TRACK) && (w_s2 != w_next_exp);
  end

  // Tracking FSM: load stable values, emit one-cycle valid and wrap pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      count_out  <= '0;
      count_vld  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      count_vld  <= w_load;
      wrap_pulse <= w_wrap;
      if (w_load) begin
        count_out <= w_s2;
      end
      case (r_state)
        ST_INIT:  if (w_load) r_state <= ST_TRACK;
        ST_TRACK: r_state <= ST_TRACK;
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  // Wrap counter and sticky skip flag; clr overrides any same-cycle event.
  // Both update on the same edge as wrap_pulse/count_vld rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_cnt <= '0;
      skip_err <= 1'b0;
    end else if (clr) begin
      wrap_cnt <= '0;
      skip_err <= 1'b0;
    end else begin
      if (w_wrap && (wrap_cnt != {WRAP_W{1'b1}})) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
      if (w_skip) begin
        skip_err <= 1'b1;
      end
    end
  end

  // Threshold compare on the registered count, one cycle behind count_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      above_thresh <= 1'b0;
    end else begin
      above_thresh <= (count_out > thresh);
    end
  end

endmodule
